// File: rtl/spi_cs_arb_pkg.sv
// Shared types and default timing for the SPI chip-select arbiter.
// The optional ACTIVE-phase watchdog is enabled by defining SPI_CS_ARB_TIMEOUT_EN.
package spi_cs_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_ACTIVE,
        ST_TRAIL,
        ST_GAP
    } arb_state_e;

    localparam int DefNumReq        = 3;
    localparam int DefLeadCycles    = 2;
    localparam int DefTrailCycles   = 2;
    localparam int DefGapCycles     = 4;
    localparam int DefTimeoutCycles = 1024;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_cs_arb_rr_pick.sv
// Combinational round-robin picker: scans requests starting just after the
// last owner and wrapping, returning the first set bit as one-hot and index.
module spi_cs_arb_rr_pick #(
    parameter  int NumReq = 3,
    localparam int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   last,
    output logic [NumReq-1:0] onehot,
    output logic [IdxW-1:0]   index,
    output logic              valid
);

    // Walk offsets 1..NumReq from the last owner so the last owner itself is
    // considered only when nobody else is requesting.
    always_comb begin
        int cand;
        onehot = '0;
        index  = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int off = 1; off <= NumReq; off++) begin
            cand = int'(last) + off;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            for (int i = 0; i < NumReq; i++) begin
                if (!valid && (i == cand) && req[i]) begin
                    valid     = 1'b1;
                    index     = IdxW'(i);
                    onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_cs_arbiter.sv
// Round-robin arbiter sharing one SPI host between NumReq requesters, with
// CS lead, trail and minimum gap sequencing. All outputs are registered.
// Define SPI_CS_ARB_TIMEOUT_EN to bound the ACTIVE phase to TimeoutCycles.
module spi_cs_arbiter
    import spi_cs_arb_pkg::*;
#(
    parameter  int NumReq        = DefNumReq,
    parameter  int LeadCycles    = DefLeadCycles,
    parameter  int TrailCycles   = DefTrailCycles,
    parameter  int GapCycles     = DefGapCycles,
    parameter  int TimeoutCycles = DefTimeoutCycles,
    localparam int IdxW          = $clog2(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    input  logic [NumReq-1:0] done_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [NumReq-1:0] cs_no,
    output logic              sck_en_o,
    output logic              busy_o,
    output logic [IdxW-1:0]   owner_o,
    output logic              timeout_o
);

    localparam int CntW = $clog2(max_int(max_int(LeadCycles, TrailCycles),
                                         max_int(GapCycles, TimeoutCycles)) + 1);

    arb_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_dec;
    logic [NumReq-1:0] cs_q, cs_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic              sck_q, sck_d;
    logic              busy_q, busy_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic              end_txn;

    logic [NumReq-1:0] pick_onehot;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_valid;

`ifdef SPI_CS_ARB_TIMEOUT_EN
    logic              timeout_q, timeout_d;
`endif

    spi_cs_arb_rr_pick #(
        .NumReq (NumReq)
    ) u_pick (
        .req    (req_i),
        .last   (ptr_q),
        .onehot (pick_onehot),
        .index  (pick_idx),
        .valid  (pick_valid)
    );

    // Saturating decrement of the shared phase counter.
    always_comb begin
        cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        gnt_d   = gnt_q;
        sck_d   = sck_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        end_txn = 1'b0;
`ifdef SPI_CS_ARB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_LEAD;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx;
                    cs_d    = ~pick_onehot;
                    cnt_d   = CntW'(LeadCycles - 1);
                end
            end
            ST_LEAD: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                    gnt_d   = ~cs_q;
                    sck_d   = 1'b1;
`ifdef SPI_CS_ARB_TIMEOUT_EN
                    cnt_d   = CntW'(TimeoutCycles - 1);
`endif
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_ACTIVE: begin
                if (done_i[owner_q] || !req_i[owner_q]) begin
                    end_txn = 1'b1;
                end
`ifdef SPI_CS_ARB_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    end_txn   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                end
`endif
                if (end_txn) begin
                    state_d = ST_TRAIL;
                    gnt_d   = '0;
                    sck_d   = 1'b0;
                    cnt_d   = CntW'(TrailCycles - 1);
                end
            end
            ST_TRAIL: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cs_d    = '1;
                    cnt_d   = CntW'(GapCycles - 1);
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = '1;
                gnt_d   = '0;
                sck_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset releases every CS and grant at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cs_q    <= '1;
            gnt_q   <= '0;
            sck_q   <= 1'b0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= IdxW'(NumReq - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            gnt_q   <= gnt_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef SPI_CS_ARB_TIMEOUT_EN
    // Single-cycle pulse marking a forced release of the bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign cs_no    = cs_q;
    assign gnt_o    = gnt_q;
    assign sck_en_o = sck_q;
    assign busy_o   = busy_q;
    assign owner_o  = owner_q;

endmodule
